// File: rtl/saph_plr_credq_if.sv
// Bus bundle for saph_plr_credq: issue gating, pipeline result capture and
// the show-ahead valid/ready output, plus credit count and error status.
//   master : upstream issuer / pipeline / consumer side (drives iss_valid,
//            res_valid, res_data, out_ready)
//   slave  : the credit queue (drives iss_ready, out_valid, out_data,
//            credits, err)
interface saph_plr_credq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 6
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             iss_valid;
  logic             iss_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    credits;
  logic             err;

  modport master (
    output iss_valid, res_valid, res_data, out_ready,
    input  iss_ready, out_valid, out_data, credits, err
  );

  modport slave (
    input  iss_valid, res_valid, res_data, out_ready,
    output iss_ready, out_valid, out_data, credits, err
  );
endinterface

// File: rtl/saph_plr_credq.sv
// Result queue behind a fixed-latency, non-stallable pipeline. Issue into the
// pipeline is gated by credits so every in-flight result always has a slot;
// results are captured as they emerge and offered show-ahead on out_valid/
// out_ready, letting a stallable consumer sit behind the pipeline.
// Ports:
//   clk  - pipeline clock
//   rst  - synchronous active-high reset, shared with the pipeline
//   bus  - saph_plr_credq_if.slave (iss_*, res_*, out_*, credits, err)
module saph_plr_credq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 6
) (
  input  logic            clk,
  input  logic            rst,
  saph_plr_credq_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Configurations that cannot sustain one issue per cycle (latency is
  // otherwise only a throughput consideration, never a logic one).
  if (DEPTH < LATENCY + 2) begin : g_below_full_rate
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_credits;
  logic             r_iss_ready;
  logic             r_out_valid;
  logic             r_err;

  logic             w_iss_fire;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_overflow;
  logic             w_cred_sat;
  logic [CW-1:0]    w_credits_nxt;
  logic [CW-1:0]    w_count_nxt;

  // Pointer advance with explicit wrap so any depth works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_iss_fire = bus.iss_valid & r_iss_ready;
  assign w_pop      = r_out_valid & bus.out_ready;
  // A push into a full queue is still fine when the head leaves this cycle.
  assign w_push_ok  = bus.res_valid & ((r_count != CW'(DEPTH)) | w_pop);
  assign w_overflow = bus.res_valid & ~w_push_ok;

  // Next credit and occupancy values.
  always_comb begin
    w_credits_nxt = r_credits;
    w_cred_sat    = 1'b0;
    w_count_nxt   = r_count;
    if (w_iss_fire && !w_pop) begin
      w_credits_nxt = r_credits - CW'(1);
    end else if (w_pop && !w_iss_fire) begin
      // Returning a credit we never lent means a result arrived unasked.
      if (r_credits == CW'(DEPTH)) begin
        w_cred_sat = 1'b1;
      end else begin
        w_credits_nxt = r_credits + CW'(1);
      end
    end
    if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push_ok) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Control state; iss_ready/out_valid are kept as registered mirrors of
  // credits != 0 and count != 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits   <= CW'(DEPTH);
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_iss_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_credits   <= w_credits_nxt;
      r_count     <= w_count_nxt;
      r_iss_ready <= (w_credits_nxt != '0);
      r_out_valid <= (w_count_nxt != '0);
      r_err       <= r_err | w_overflow | w_cred_sat;
      if (w_push_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.res_data;
    end
  end

  assign bus.iss_ready = r_iss_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign bus.credits   = r_credits;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_saph_plr_credq.sv
// Self-checking bench for saph_plr_credq: a depth-6 and a depth-4 instance
// share stimulus; a small fixed-latency pipeline model feeds res_valid.
module tb_saph_plr_credq;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             iss_valid;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             out_ready;
  logic             sel4;

  always #5 clk = ~clk;

  saph_plr_credq_if #(.WIDTH(WIDTH), .DEPTH(6)) bus6 ();
  saph_plr_credq_if #(.WIDTH(WIDTH), .DEPTH(4)) bus4 ();

  assign bus6.iss_valid = iss_valid;
  assign bus6.res_valid = res_valid;
  assign bus6.res_data  = res_data;
  assign bus6.out_ready = out_ready;
  assign bus4.iss_valid = iss_valid;
  assign bus4.res_valid = res_valid;
  assign bus4.res_data  = res_data;
  assign bus4.out_ready = out_ready;

  saph_plr_credq #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .bus(bus6.slave));
  saph_plr_credq #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  logic             m_iss_ready, m_out_valid, m_err;
  logic [WIDTH-1:0] m_out_data;
  logic [2:0]       m_credits;
  assign m_iss_ready = sel4 ? bus4.iss_ready : bus6.iss_ready;
  assign m_out_valid = sel4 ? bus4.out_valid : bus6.out_valid;
  assign m_out_data  = sel4 ? bus4.out_data  : bus6.out_data;
  assign m_credits   = sel4 ? bus4.credits   : bus6.credits;
  assign m_err       = sel4 ? bus4.err       : bus6.err;

  int n_chk = 0;
  int n_fail = 0;

  // Pipeline model and occupancy model
  logic             pv [LAT];
  logic [WIDTH-1:0] pd [LAT];
  logic [WIDTH-1:0] iss_data;
  int               q_cnt;

  typedef struct {
    logic        iss_v;
    logic        out_r;
    logic        exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_data;
    int          exp_cred;
    logic        exp_err;
  } vec_t;
  vec_t t2 [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, advance models after it.
  task automatic cycle();
    logic fire, pop, push_ok;
    int   dep;
    dep     = sel4 ? 4 : 6;
    fire    = iss_valid & m_iss_ready & ~rst;
    pop     = m_out_valid & out_ready & ~rst;
    push_ok = res_valid & ((q_cnt < dep) | pop) & ~rst;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] = 1'b0;
        pd[i] = '0;
      end
      q_cnt = 0;
    end else begin
      q_cnt = q_cnt + (push_ok ? 1 : 0) - (pop ? 1 : 0);
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = fire;
      pd[0] = iss_data;
      if (fire) iss_data = iss_data + 1;
    end
    res_valid = pv[LAT-1];
    res_data  = pd[LAT-1];
  endtask

  task automatic do_reset(input logic use4);
    sel4      = use4;
    rst       = 1'b1;
    iss_valid = 1'b0;
    res_valid = 1'b0;
    out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  function automatic int in_flight();
    int s = 0;
    for (int i = 0; i < LAT; i++) s += pv[i] ? 1 : 0;
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops, order_err, inv_err, pops;
    logic [WIDTH-1:0] exp_next;

    t2[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  4, 1'b0};
    t2[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  3, 1'b0};
    t2[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  2, 1'b0};
    t2[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1, 1'b0};
    t2[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  0, 1'b0};
    t2[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hA0, 0, 1'b0};
    t2[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 1, 1'b0};
    t2[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA2, 2, 1'b0};
    t2[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hA3, 3, 1'b0};
    t2[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  4, 1'b0};

    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    q_cnt = 0; iss_data = '0; sel4 = 1'b0;
    rst = 1'b1; iss_valid = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;

    // 1: reset with issue and result requests active
    sel4 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iss_valid = 1'b1; res_valid = 1'b1; res_data = 32'h77;
      cycle();
      chk($sformatf("t1 rst%0d credits", k), 32'(m_credits), 32'd6);
      chk($sformatf("t1 rst%0d iss_ready", k), 32'(m_iss_ready), 32'd1);
      chk($sformatf("t1 rst%0d out_valid", k), 32'(m_out_valid), 32'd0);
      chk($sformatf("t1 rst%0d err", k), 32'(m_err), 32'd0);
    end
    rst = 1'b0; iss_valid = 1'b0; res_valid = 1'b0;
    cycle();
    chk("t1 post credits", 32'(m_credits), 32'd6);
    chk("t1 post iss_ready", 32'(m_iss_ready), 32'd1);
    chk("t1 post out_valid", 32'(m_out_valid), 32'd0);
    chk("t1 post err", 32'(m_err), 32'd0);

    // 2: credit exhaustion, depth 4, table driven
    do_reset(1'b1);
    iss_data = 32'hA0;
    for (int i = 0; i < 10; i++) begin
      iss_valid = t2[i].iss_v;
      out_ready = t2[i].out_r;
      chk($sformatf("t2[%0d] iss_ready", i), 32'(m_iss_ready), 32'(t2[i].exp_rdy));
      chk($sformatf("t2[%0d] out_valid", i), 32'(m_out_valid), 32'(t2[i].exp_ov));
      chk($sformatf("t2[%0d] credits", i), 32'(m_credits), 32'(t2[i].exp_cred));
      chk($sformatf("t2[%0d] err", i), 32'(m_err), 32'(t2[i].exp_err));
      if (t2[i].exp_ov) chk($sformatf("t2[%0d] out_data", i), m_out_data, t2[i].exp_data);
      cycle();
    end

    // 3: full throughput, depth 6
    do_reset(1'b0);
    iss_data = 32'h1000; exp_next = 32'h1000; out_ready = 1'b1;
    drops = 0; order_err = 0; inv_err = 0; pops = 0;
    for (int c = 0; c < 130; c++) begin
      iss_valid = (c < 100);
      if (c < 100 && !m_iss_ready) drops++;
      if (m_out_valid) begin
        if (m_out_data !== exp_next) order_err++;
        exp_next = exp_next + 1;
        pops++;
      end
      if (32'(m_credits) + q_cnt + in_flight() != 6) inv_err++;
      cycle();
    end
    chk("t3 iss_ready drops", 32'(drops), 32'd0);
    chk("t3 order errors", 32'(order_err), 32'd0);
    chk("t3 results out", 32'(pops), 32'd100);
    chk("t3 invariant errors", 32'(inv_err), 32'd0);
    chk("t3 err", 32'(m_err), 32'd0);

    // 4: consumer stall, depth 6
    do_reset(1'b0);
    iss_data = 32'hB0; out_ready = 1'b0; iss_valid = 1'b1;
    for (int c = 0; c < 20 && iss_data != 32'hB6; c++) cycle();
    chk("t4 fires", iss_data - 32'hB0, 32'd6);
    drops = 0;
    for (int c = 0; c < 8; c++) begin
      if (m_iss_ready) drops++;
      cycle();
    end
    chk("t4 iss_ready high while empty", 32'(drops), 32'd0);
    chk("t4 credits", 32'(m_credits), 32'd0);
    chk("t4 out_valid", 32'(m_out_valid), 32'd1);
    chk("t4 head", m_out_data, 32'hB0);
    iss_valid = 1'b0; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t4 credits after pop", 32'(m_credits), 32'd1);
    chk("t4 iss_ready after pop", 32'(m_iss_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      chk($sformatf("t4 drain%0d valid", k), 32'(m_out_valid), 32'd1);
      chk($sformatf("t4 drain%0d data", k), m_out_data, 32'hB0 + 32'(k));
      cycle();
    end
    chk("t4 empty", 32'(m_out_valid), 32'd0);
    chk("t4 credits refilled", 32'(m_credits), 32'd6);
    chk("t4 err", 32'(m_err), 32'd0);

    // 5: push+pop when full, then overflow, depth 4
    do_reset(1'b1);
    iss_data = 32'hC0; out_ready = 1'b0; iss_valid = 1'b1;
    for (int c = 0; c < 10; c++) cycle();
    iss_valid = 1'b0;
    chk("t5 full credits", 32'(m_credits), 32'd0);
    chk("t5 full head", m_out_data, 32'hC0);
    res_valid = 1'b1; res_data = 32'hF0; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t5 pp credits", 32'(m_credits), 32'd1);
    chk("t5 pp head", m_out_data, 32'hC1);
    chk("t5 pp err", 32'(m_err), 32'd0);
    res_valid = 1'b1; res_data = 32'hF1;
    cycle();
    chk("t5 ovf err", 32'(m_err), 32'd1);
    chk("t5 ovf head", m_out_data, 32'hC1);
    chk("t5 ovf credits", 32'(m_credits), 32'd1);
    for (int c = 0; c < 3; c++) cycle();
    chk("t5 err sticky", 32'(m_err), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = (k < 3) ? 32'hC1 + 32'(k) : 32'hF0;
      chk($sformatf("t5 drain%0d valid", k), 32'(m_out_valid), 32'd1);
      chk($sformatf("t5 drain%0d data", k), m_out_data, e);
      cycle();
    end
    chk("t5 empty", 32'(m_out_valid), 32'd0);
    chk("t5 err held", 32'(m_err), 32'd1);
    do_reset(1'b1);
    chk("t5 err cleared", 32'(m_err), 32'd0);

    // 6: spurious result, depth 6
    do_reset(1'b0);
    res_valid = 1'b1; res_data = 32'h55; out_ready = 1'b0;
    cycle();
    chk("t6 valid", 32'(m_out_valid), 32'd1);
    chk("t6 data", m_out_data, 32'h55);
    chk("t6 credits before pop", 32'(m_credits), 32'd6);
    chk("t6 err before pop", 32'(m_err), 32'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t6 credits saturated", 32'(m_credits), 32'd6);
    chk("t6 err", 32'(m_err), 32'd1);
    chk("t6 empty", 32'(m_out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
